// File: rtl/fp_addsub_param.sv
// Multi-cycle floating-point add/subtract with round-to-nearest-even, special-value
// handling and exception flags. One operation in flight; denormal inputs flush to zero.
module fp_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   X,
  input  logic [EXP_W+MAN_W:0]   Y,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic                   valid,
  output logic                   busy,
  output logic [3:0]             flags
);
  localparam int W   = EXP_W + MAN_W + 1;
  localparam int MW  = MAN_W + 4;  // hidden, fraction, guard, round, sticky
  localparam int EW1 = EXP_W + 1;
  localparam logic [EW1-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [W-1:0]   QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Handshake: start is sampled only in IDLE; busy is high in every other state;
  // valid is a one-cycle strobe in DONE, when sum/flags already hold the new result.
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
  state_t state_q, state_d;

  logic [W-1:0]   x_q, x_d, y_q, y_d, sum_q, sum_d;
  logic           op_q, op_d, sign_q, sign_d, sign_s_q, sign_s_d;
  logic [3:0]     flags_q, flags_d;
  logic [EW1-1:0] exp_q, exp_d;
  logic [MW-1:0]  man_l_q, man_l_d, man_s_q, man_s_d;
  logic [MW:0]    mant_q, mant_d;

  // Operand decode
  logic [EXP_W-1:0] x_exp, y_exp, exp_l, exp_s, exp_diff;
  logic [MAN_W-1:0] x_frac, y_frac;
  logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, eff_ys, x_ge;
  logic [MW-1:0] man_big, man_sml, man_lost, man_al;

  assign x_exp   = x_q[W-2:MAN_W];
  assign y_exp   = y_q[W-2:MAN_W];
  assign x_frac  = x_q[MAN_W-1:0];
  assign y_frac  = y_q[MAN_W-1:0];
  assign x_nan   = (&x_exp) & (|x_frac);
  assign y_nan   = (&y_exp) & (|y_frac);
  assign x_inf   = (&x_exp) & ~(|x_frac);
  assign y_inf   = (&y_exp) & ~(|y_frac);
  assign x_zero  = ~(|x_exp);
  assign y_zero  = ~(|y_exp);
  assign eff_ys  = y_q[W-1] ^ op_q;
  assign x_ge    = x_q[W-2:0] >= y_q[W-2:0];
  assign exp_l   = x_ge ? x_exp : y_exp;
  assign exp_s   = x_ge ? y_exp : x_exp;
  assign exp_diff = exp_l - exp_s;
  assign man_big = {1'b1, (x_ge ? x_frac : y_frac), 3'b000};
  assign man_sml = {1'b1, (x_ge ? y_frac : x_frac), 3'b000};
  // Shifts of MW or more give zero from the shifter and an all-ones mask, leaving only S.
  assign man_lost = man_sml & ~({MW{1'b1}} << exp_diff);
  assign man_al   = (man_sml >> exp_diff) | {{(MW-1){1'b0}}, |man_lost};

  // Rounding on the normalised mantissa; a fraction carry-out means 1.0 at exp+1
  logic             rnd_inc, rnd_carry, rnd_inexact;
  logic [MAN_W-1:0] rnd_frac;
  logic [EW1-1:0]   rnd_exp, exp_inc, exp_dec;

  assign rnd_inc     = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
  assign rnd_inexact = mant_q[2] | mant_q[1] | mant_q[0];
  assign {rnd_carry, rnd_frac} = {1'b0, mant_q[MW-2:3]} + {{MAN_W{1'b0}}, rnd_inc};
  assign rnd_exp = exp_q + {{EXP_W{1'b0}}, rnd_carry};
  assign exp_inc = exp_q + EW1'(1);
  assign exp_dec = exp_q - EW1'(1);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    op_d     = op_q;
    sum_d    = sum_q;
    flags_d  = flags_q;
    sign_d   = sign_q;
    sign_s_d = sign_s_q;
    exp_d    = exp_q;
    man_l_d  = man_l_q;
    man_s_d  = man_s_q;
    mant_d   = mant_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = X;
          y_d     = Y;
          op_d    = op;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        state_d = S_DONE;
        flags_d = 4'b0000;
        if (x_nan | y_nan) begin
          sum_d = QNAN;
        end else if (x_inf & y_inf & (x_q[W-1] != eff_ys)) begin
          sum_d   = QNAN;
          flags_d = 4'b1000;
        end else if (x_inf) begin
          sum_d = x_q;
        end else if (y_inf) begin
          sum_d = {eff_ys, y_q[W-2:0]};
        end else if (x_zero & y_zero) begin
          sum_d = {x_q[W-1] & eff_ys, {(W-1){1'b0}}};
        end else if (x_zero) begin
          sum_d = {eff_ys, y_q[W-2:0]};
        end else if (y_zero) begin
          sum_d = x_q;
        end else begin
          state_d  = S_ADD;
          flags_d  = flags_q;
          sign_d   = x_ge ? x_q[W-1] : eff_ys;
          sign_s_d = x_ge ? eff_ys : x_q[W-1];
          exp_d    = {1'b0, exp_l};
          man_l_d  = man_big;
          man_s_d  = man_al;
        end
      end
      S_ADD: begin
        mant_d  = (sign_q == sign_s_q) ? ({1'b0, man_l_q} + {1'b0, man_s_q})
                                       : ({1'b0, man_l_q} - {1'b0, man_s_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        if (mant_q == '0) begin
          sum_d   = '0;
          flags_d = 4'b0000;
          state_d = S_DONE;
        end else if (mant_q[MW]) begin
          mant_d = {1'b0, mant_q[MW:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_inc;
          if (exp_inc == EXP_MAX) begin
            sum_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d = 4'b0101;
            state_d = S_DONE;
          end
        end else if (!mant_q[MW-1]) begin
          mant_d = {mant_q[MW-1:0], 1'b0};
          exp_d  = exp_dec;
          if (exp_dec == '0) begin
            sum_d   = {sign_q, {(W-1){1'b0}}};
            flags_d = 4'b0011;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (rnd_exp == EXP_MAX) begin
          sum_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = {1'b0, 1'b1, 1'b0, rnd_inexact};
        end else begin
          sum_d   = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
          flags_d = {3'b000, rnd_inexact};
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      op_q     <= 1'b0;
      sum_q    <= '0;
      flags_q  <= '0;
      sign_q   <= 1'b0;
      sign_s_q <= 1'b0;
      exp_q    <= '0;
      man_l_q  <= '0;
      man_s_q  <= '0;
      mant_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      op_q     <= op_d;
      sum_q    <= sum_d;
      flags_q  <= flags_d;
      sign_q   <= sign_d;
      sign_s_q <= sign_s_d;
      exp_q    <= exp_d;
      man_l_q  <= man_l_d;
      man_s_q  <= man_s_d;
      mant_q   <= mant_d;
    end
  end

  assign sum   = sum_q;
  assign flags = flags_q;
  assign valid = (state_q == S_DONE);
  assign busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_fp_addsub_param.sv
// Directed-vector bench for fp_addsub_param: single precision plus a half-precision
// instance, checking result, flags and latency for each operation.
module tb_fp_addsub_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_start = 1'b0, a_op = 1'b0;
  logic [31:0] a_x = '0, a_y = '0, a_sum;
  logic        a_valid, a_busy;
  logic [3:0]  a_flags;
  logic        h_start = 1'b0, h_op = 1'b0;
  logic [15:0] h_x = '0, h_y = '0, h_sum;
  logic        h_valid, h_busy;
  logic [3:0]  h_flags;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        op;
    logic [31:0] s;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  fp_addsub_param dut (
    .clk(clk), .rst(rst), .start(a_start), .op(a_op), .X(a_x), .Y(a_y),
    .sum(a_sum), .valid(a_valid), .busy(a_busy), .flags(a_flags)
  );

  fp_addsub_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .start(h_start), .op(h_op), .X(h_x), .Y(h_y),
    .sum(h_sum), .valid(h_valid), .busy(h_busy), .flags(h_flags)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  // Driver: issue one op, return result and latency in edges after the start edge
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic opv,
                       output logic [31:0] s, output logic [3:0] f, output int lat);
    @(negedge clk);
    a_x = x; a_y = y; a_op = opv; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    lat = 0;
    while (a_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    s = a_sum;
    f = a_flags;
  endtask

  task automatic do_op_h(input logic [15:0] x, input logic [15:0] y, input logic opv,
                         output logic [15:0] s, output logic [3:0] f, output int lat);
    @(negedge clk);
    h_x = x; h_y = y; h_op = opv; h_start = 1'b1;
    @(negedge clk);
    h_start = 1'b0;
    lat = 0;
    while (h_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    s = h_sum;
    f = h_flags;
  endtask

  task automatic run_table(input string tag, input vec_t v[$]);
    logic [31:0] s;
    logic [3:0]  f;
    int          lat;
    foreach (v[i]) begin
      do_op(v[i].x, v[i].y, v[i].op, s, f, lat);
      n_checks++;
      if (s !== v[i].s || f !== v[i].f || lat != v[i].lat)
        $display("FAIL %s[%0d]: sum=%h flags=%b lat=%0d, expected sum=%h flags=%b lat=%0d",
                 tag, i, s, f, lat, v[i].s, v[i].f, v[i].lat);
      else
        n_pass++;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_checks++;
    if ({a_sum, a_valid, a_busy, a_flags} !== '0 || {h_sum, h_valid, h_busy, h_flags} !== '0)
      $display("FAIL reset: sum=%h valid=%b busy=%b flags=%b, expected all zero",
               a_sum, a_valid, a_busy, a_flags);
    else
      n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // 1.0 + 1.0 with busy/valid traced edge by edge
  task automatic test_add_basic();
    logic [1:0] want;
    @(negedge clk);
    a_x = 32'h3F800000; a_y = 32'h3F800000; a_op = 1'b0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      want = {(e <= 5) ? 1'b1 : 1'b0, (e == 5) ? 1'b1 : 1'b0};
      n_checks++;
      if ({a_busy, a_valid} !== want)
        $display("FAIL busy_valid after edge %0d: busy,valid=%b, expected %b", e, {a_busy, a_valid}, want);
      else
        n_pass++;
      if (e < 6) @(negedge clk);
    end
    n_checks++;
    if (a_sum !== 32'h40000000 || a_flags !== 4'b0000)
      $display("FAIL add_basic: sum=%h flags=%b, expected 40000000 0000", a_sum, a_flags);
    else
      n_pass++;
  endtask

  task automatic test_cancel();
    vec_t v[$];
    v.push_back('{x:32'h3F800001, y:32'h3F800000, op:1'b1, s:32'h34000000, f:4'b0000, lat:27});
    v.push_back('{x:32'h3F800001, y:32'h3F800000, op:1'b0, s:32'h40000000, f:4'b0001, lat:5});
    v.push_back('{x:32'h3F800001, y:32'h3F800001, op:1'b1, s:32'h00000000, f:4'b0000, lat:3});
    v.push_back('{x:32'h00800001, y:32'h00800000, op:1'b1, s:32'h00000000, f:4'b0011, lat:3});
    run_table("cancel", v);
  endtask

  task automatic test_round();
    vec_t v[$];
    v.push_back('{x:32'h3F800000, y:32'h33800000, op:1'b0, s:32'h3F800000, f:4'b0001, lat:4});
    v.push_back('{x:32'h3F800001, y:32'h33800000, op:1'b0, s:32'h3F800002, f:4'b0001, lat:4});
    v.push_back('{x:32'h3F800000, y:32'h30800000, op:1'b0, s:32'h3F800000, f:4'b0001, lat:4});
    v.push_back('{x:32'h3F800000, y:32'h30800000, op:1'b1, s:32'h3F800000, f:4'b0001, lat:5});
    v.push_back('{x:32'h7F7FFFFF, y:32'h7F7FFFFF, op:1'b0, s:32'h7F800000, f:4'b0101, lat:3});
    run_table("round", v);
  endtask

  task automatic test_specials();
    vec_t v[$];
    v.push_back('{x:32'h7F800000, y:32'h7F800000, op:1'b1, s:32'h7FC00000, f:4'b1000, lat:1});
    v.push_back('{x:32'h00000000, y:32'h40400000, op:1'b1, s:32'hC0400000, f:4'b0000, lat:1});
    v.push_back('{x:32'h40400000, y:32'h00000000, op:1'b1, s:32'h40400000, f:4'b0000, lat:1});
    v.push_back('{x:32'h7FC00001, y:32'h3F800000, op:1'b0, s:32'h7FC00000, f:4'b0000, lat:1});
    v.push_back('{x:32'h3F800000, y:32'h7F800000, op:1'b1, s:32'hFF800000, f:4'b0000, lat:1});
    v.push_back('{x:32'h80000000, y:32'h80000000, op:1'b0, s:32'h80000000, f:4'b0000, lat:1});
    v.push_back('{x:32'h80000000, y:32'h80000000, op:1'b1, s:32'h00000000, f:4'b0000, lat:1});
    run_table("specials", v);
  endtask

  // start re-asserted while busy must be ignored
  task automatic test_start_while_busy();
    int nval;
    nval = 0;
    @(negedge clk);
    a_x = 32'h3F800000; a_y = 32'h3F800000; a_op = 1'b0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (c <= 3) begin
        a_x = 32'h40400000; a_start = 1'b1;
      end else begin
        a_start = 1'b0;
      end
      @(negedge clk);
      if (a_valid === 1'b1) nval++;
    end
    n_checks++;
    if (nval != 1 || a_sum !== 32'h40000000)
      $display("FAIL start_while_busy: valids=%0d sum=%h, expected 1 valid sum=40000000", nval, a_sum);
    else
      n_pass++;
  endtask

  task automatic test_reset_mid();
    int nval;
    logic [31:0] s;
    logic [3:0]  f;
    int          lat;
    @(negedge clk);
    a_x = 32'h3F800001; a_y = 32'h3F800000; a_op = 1'b1; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({a_sum, a_valid, a_busy, a_flags} !== '0)
      $display("FAIL reset_mid: sum=%h valid=%b busy=%b flags=%b, expected all zero",
               a_sum, a_valid, a_busy, a_flags);
    else
      n_pass++;
    @(negedge clk);
    rst = 1'b1;
    nval = 0;
    repeat (30) begin
      @(negedge clk);
      if (a_valid === 1'b1) nval++;
    end
    n_checks++;
    if (nval != 0 || a_busy !== 1'b0)
      $display("FAIL reset_abort: valids=%0d busy=%b, expected 0 valids busy=0", nval, a_busy);
    else
      n_pass++;
    do_op(32'h3F800000, 32'h3F800000, 1'b0, s, f, lat);
    n_checks++;
    if (s !== 32'h40000000 || f !== 4'b0000 || lat != 5)
      $display("FAIL after_reset: sum=%h flags=%b lat=%0d, expected 40000000 0000 5", s, f, lat);
    else
      n_pass++;
  endtask

  task automatic test_half();
    logic [15:0] s;
    logic [3:0]  f;
    int          lat;
    do_op_h(16'h3C00, 16'h3C00, 1'b0, s, f, lat);
    n_checks++;
    if (s !== 16'h4000 || f !== 4'b0000 || lat != 5)
      $display("FAIL half_add: sum=%h flags=%b lat=%0d, expected 4000 0000 5", s, f, lat);
    else
      n_pass++;
    do_op_h(16'h7BFF, 16'h7BFF, 1'b0, s, f, lat);
    n_checks++;
    if (s !== 16'h7C00 || f !== 4'b0101 || lat != 3)
      $display("FAIL half_ovf: sum=%h flags=%b lat=%0d, expected 7c00 0101 3", s, f, lat);
    else
      n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_cancel();
    test_round();
    test_specials();
    test_start_while_busy();
    test_reset_mid();
    test_half();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
